// File: rtl/decode_stage_p.sv
// Decode stage: 8-entry register bank, field decode, RAW scoreboard with optional
// write-back bypass, and one registered valid/ready output stage toward the ALU.
module decode_stage_p #(
    parameter int DATA_W  = 16,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [15:0]       i_ins,
    input  logic              i_flush,
    input  logic              i_wb_en,
    input  logic [2:0]        i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_r1_data,
    output logic [DATA_W-1:0] o_r2_data,
    output logic [DATA_W-1:0] o_imm_data,
    output logic [2:0]        o_rd,
    output logic [2:0]        o_aluop,
    output logic              o_wr_en
);

    localparam logic L_BYP = (BYPASS != 0);
    localparam logic L_Z0  = (ZERO_R0 != 0);

    logic [DATA_W-1:0] r_bank [8];
    logic              r_pending [8];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_r1_data;
    logic [DATA_W-1:0] r_r2_data;
    logic [DATA_W-1:0] r_imm_data;
    logic [2:0]        r_rd;
    logic [2:0]        r_aluop;
    logic              r_wr_en;

    logic [2:0]        w_opc;
    logic [2:0]        w_rs1;
    logic [2:0]        w_rs2;
    logic [2:0]        w_rd;
    logic [3:0]        w_func;
    logic              w_wr_en;
    logic [2:0]        w_aluop;
    logic [7:0]        w_wb_hit;
    logic [7:0]        w_hz;
    logic              w_stall;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_r1_data;
    logic [DATA_W-1:0] w_r2_data;

    assign w_opc  = i_ins[15:13];
    assign w_rs1  = i_ins[12:10];
    assign w_rs2  = i_ins[9:7];
    assign w_rd   = i_ins[6:4];
    assign w_func = i_ins[3:0];

    // Top opcode bit selects the non-writing class, which also forces aluop[1:0] to 0.
    assign w_wr_en   = ~w_opc[2];
    assign w_aluop   = {w_wr_en & (w_func == 4'd2), w_opc[2] ? 2'b00 : w_opc[1:0]};

    assign w_stall    = i_in_valid & (w_hz[w_rs1] | w_hz[w_rs2]);
    assign w_in_ready = ~w_stall & (~r_out_valid | i_out_ready);
    assign w_accept   = i_in_valid & w_in_ready & ~i_flush;

    function automatic logic [DATA_W-1:0] f_read(
        input logic [2:0]        rs,
        input logic [DATA_W-1:0] bank_val,
        input logic              wb_en,
        input logic [2:0]        wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] val;
        val = bank_val;
        if (L_Z0 && rs == 3'd0)
            val = '0;
        else if (L_BYP && wb_en && wb_rd == rs)
            val = wb_data;
        return val;
    endfunction

    assign w_r1_data = f_read(w_rs1, r_bank[w_rs1], i_wb_en, i_wb_rd, i_wb_data);
    assign w_r2_data = f_read(w_rs2, r_bank[w_rs2], i_wb_en, i_wb_rd, i_wb_data);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            localparam logic L_FIXED0 = L_Z0 && (gi == 0);

            assign w_wb_hit[gi] = i_wb_en && (i_wb_rd == 3'(gi));
            // A write-back landing this cycle resolves the hazard only when it can be forwarded.
            assign w_hz[gi] = r_pending[gi] && !(w_wb_hit[gi] && L_BYP) && !L_FIXED0;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_bank[gi] <= '0;
                else if (w_wb_hit[gi] && !L_FIXED0)
                    r_bank[gi] <= i_wb_data;
            end

            // Set has priority so a new writer is not lost to an older write-back.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_pending[gi] <= 1'b0;
                else if (w_accept && w_wr_en && (w_rd == 3'(gi)) && !L_FIXED0)
                    r_pending[gi] <= 1'b1;
                else if (w_wb_hit[gi])
                    r_pending[gi] <= 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_r1_data   <= '0;
            r_r2_data   <= '0;
            r_imm_data  <= '0;
            r_rd        <= 3'd0;
            r_aluop     <= 3'd0;
            r_wr_en     <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_r1_data   <= w_r1_data;
            r_r2_data   <= w_r2_data;
            r_imm_data  <= {{(DATA_W-3){1'b0}}, w_rs1};
            r_rd        <= w_rd;
            r_aluop     <= w_aluop;
            r_wr_en     <= w_wr_en;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_r1_data   = r_r1_data;
    assign o_r2_data   = r_r2_data;
    assign o_imm_data  = r_imm_data;
    assign o_rd        = r_rd;
    assign o_aluop     = r_aluop;
    assign o_wr_en     = r_wr_en;

endmodule
